excp_ctrl: RTL and testbench
============================

EXCP_CTRL -- requirements
Module: excp_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  clock, rising edge; rst_n  input  1  reset, asynchronous, active-low.
REQ-002 SHALL have: mem_valid_i  input  1  valid instruction in MEM stage.
REQ-003 SHALL have: mem_pc_i  input  32  PC of MEM-stage instruction; mem_in_delay_slot_i  input  1  instruction is in a branch delay slot.
REQ-004 SHALL have: mem_excp_i  input  5  [0] syscall, [1] break, [2] reserved instruction, [3] overflow, [4] eret.
REQ-005 SHALL have: cp0_we_i  input  1, cp0_waddr_i  input  5, cp0_wdata_i  input  32  pending MEM-stage CP0 write (bypass source).
REQ-006 SHALL have: status_i, cause_i, epc_i  input  32 each  current CP0 Status(12), Cause(13), EPC(14).
REQ-007 SHALL have: flush_o  output  1  pipeline flush pulse; new_pc_o  output  32  redirect target.
REQ-008 SHALL have: excp_valid_o  output  1  CP0 exception-update strobe; excp_code_o  output  5  ExcCode; excp_epc_o  output  32; excp_bd_o  output  1; eret_o  output  1  clear-EXL strobe.
REQ-009 SHALL have: busy_o  output  1  high when FSM is not IDLE.

Function
REQ-010 SHALL form effective Status/Cause/EPC combinationally: cp0_wdata_i replaces status_i/cause_i/epc_i when cp0_we_i=1 and cp0_waddr_i equals 12/13/14 respectively; Cause bypass replaces only bits [9:8].
REQ-011 SHALL compute int_pend = |(eff_cause[15:8] & eff_status[15:8]) & eff_status[0] & ~eff_status[1].
REQ-012 SHALL evaluate events only when mem_valid_i=1 and FSM in IDLE; otherwise all inputs ignored.
REQ-013 SHALL apply fixed priority: interrupt > reserved instr > syscall > break > overflow > eret; exactly one event taken per evaluation.
REQ-014 SHALL use ExcCode: interrupt 0x00, syscall 0x08, break 0x09, reserved instr 0x0A, overflow 0x0C.
REQ-015 SHALL set excp_epc_o = mem_pc_i - 4 and excp_bd_o=1 when mem_in_delay_slot_i=1, else mem_pc_i and 0 (32-bit modular subtraction).
REQ-016 SHALL set new_pc_o = 0x0000_0020 for any exception; eff_epc for eret.
REQ-017 SHALL register all outputs: event detected in cycle N -> flush_o, new_pc_o and strobes valid in cycle N+1 for exactly one cycle.
REQ-018 SHALL assert excp_valid_o (with code/epc/bd) for exceptions only; eret_o for eret only; never both in one cycle.
REQ-019 SHALL implement FSM IDLE -> FLUSH on taken event; FLUSH -> BLANK after 1 cycle; BLANK holds 2 cycles (2-bit counter) then -> IDLE.
REQ-020 SHALL ignore all events in FLUSH and BLANK (refill bubbles); events during these cycles are dropped, not queued.
REQ-021 SHALL hold new_pc_o, excp_code_o, excp_epc_o, excp_bd_o stable from FLUSH until next taken event.
REQ-022 SHALL treat mem_excp_i=0 with int_pend=0 as no event; FSM stays IDLE, all strobes 0.
REQ-023 SHALL take interrupt when int_pend=1 even if mem_excp_i also has bits set (interrupt wins, instruction not retired).

Reset
REQ-024 SHALL on rst_n=0 force FSM to IDLE, counter 0, flush_o=0, excp_valid_o=0, eret_o=0, busy_o=0, new_pc_o=0, excp_code_o=0, excp_epc_o=0, excp_bd_o=0, asynchronously.
REQ-025 SHALL, on reset asserted mid-FLUSH/BLANK, abort the sequence with no further strobes after release.
REQ-026 SHALL evaluate events from the first rising edge after rst_n deasserts.

Verification
REQ-027 SHALL cover: pc=0x100, mem_excp_i=00001 -> next cycle flush_o=1, new_pc_o=0x20, excp_code_o=0x08, excp_epc_o=0x100, busy_o high 3 cycles.
REQ-028 SHALL cover: status_i=0x0000_0401, cause_i[10]=1, mem_excp_i=00100 -> interrupt taken, excp_code_o=0x00.
REQ-029 SHALL cover: delay slot=1, pc=0x204, overflow -> excp_epc_o=0x200, excp_bd_o=1, excp_code_o=0x0C.
REQ-030 SHALL cover: epc_i=0x40, cp0_we_i=1 addr 14 wdata 0x80, eret -> new_pc_o=0x80, eret_o=1, excp_valid_o=0.
REQ-031 SHALL cover: syscall followed by break on next 2 cycles -> only syscall taken, single flush pulse.
REQ-032 SHALL cover: rst_n low during BLANK -> all outputs 0, no flush after release until a new event.

Source files
------------

// File: rtl/excp_ctrl.sv
// ============================================================================
// Module   : excp_ctrl
// Purpose  : MEM-stage exception/interrupt/eret arbiter with CP0 bypass and
//            flush/refill sequencing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module excp_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delay_slot_i,
    input  logic [4:0]  mem_excp_i,
    input  logic        cp0_we_i,
    input  logic [4:0]  cp0_waddr_i,
    input  logic [31:0] cp0_wdata_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        excp_valid_o,
    output logic [4:0]  excp_code_o,
    output logic [31:0] excp_epc_o,
    output logic        excp_bd_o,
    output logic        eret_o,
    output logic        busy_o
);

    localparam logic [4:0]  CP0_STATUS   = 5'd12;
    localparam logic [4:0]  CP0_CAUSE    = 5'd13;
    localparam logic [4:0]  CP0_EPC      = 5'd14;
    localparam logic [4:0]  EXC_INT      = 5'h00;
    localparam logic [4:0]  EXC_SYS      = 5'h08;
    localparam logic [4:0]  EXC_BP       = 5'h09;
    localparam logic [4:0]  EXC_RI       = 5'h0A;
    localparam logic [4:0]  EXC_OV       = 5'h0C;
    localparam logic [31:0] EXC_VECTOR   = 32'h0000_0020;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_BLANK = 2'd2
    } state_e;

    state_e      state_q;
    logic [1:0]  cnt_q;
    logic        flush_q;
    logic [31:0] new_pc_q;
    logic        excp_valid_q;
    logic [4:0]  excp_code_q;
    logic [31:0] excp_epc_q;
    logic        excp_bd_q;
    logic        eret_q;
    logic        busy_q;

    logic [31:0] eff_status;
    logic [31:0] eff_cause;
    logic [31:0] eff_epc;
    logic        int_pend;
    logic        excp_hit;
    logic        eret_hit;
    logic        take;
    logic [4:0]  excp_code_d;
    logic [31:0] excp_epc_d;
    logic        excp_bd_d;
    logic        unused_bits;

    // Bypass the in-flight MEM-stage mtc0 so a just-written register is seen.
    always_comb begin
        eff_status = status_i;
        eff_cause  = cause_i;
        eff_epc    = epc_i;
        if (cp0_we_i && (cp0_waddr_i == CP0_STATUS)) eff_status = cp0_wdata_i;
        if (cp0_we_i && (cp0_waddr_i == CP0_CAUSE))  eff_cause[9:8] = cp0_wdata_i[9:8];
        if (cp0_we_i && (cp0_waddr_i == CP0_EPC))    eff_epc = cp0_wdata_i;
    end

    assign unused_bits = ^{eff_status[31:16], eff_status[7:2],
                           eff_cause[31:16], eff_cause[7:0]};

    assign int_pend = (|(eff_cause[15:8] & eff_status[15:8]))
                      & eff_status[0] & ~eff_status[1];

    always_comb begin
        excp_code_d = EXC_INT;
        if (int_pend)           excp_code_d = EXC_INT;
        else if (mem_excp_i[2]) excp_code_d = EXC_RI;
        else if (mem_excp_i[0]) excp_code_d = EXC_SYS;
        else if (mem_excp_i[1]) excp_code_d = EXC_BP;
        else if (mem_excp_i[3]) excp_code_d = EXC_OV;
    end

    assign excp_hit   = int_pend | (|mem_excp_i[3:0]);
    assign eret_hit   = ~excp_hit & mem_excp_i[4];
    assign take       = mem_valid_i && (state_q == S_IDLE) && (excp_hit || eret_hit);
    assign excp_epc_d = mem_in_delay_slot_i ? (mem_pc_i - 32'd4) : mem_pc_i;
    assign excp_bd_d  = mem_in_delay_slot_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            flush_q      <= 1'b0;
            new_pc_q     <= 32'd0;
            excp_valid_q <= 1'b0;
            excp_code_q  <= 5'd0;
            excp_epc_q   <= 32'd0;
            excp_bd_q    <= 1'b0;
            eret_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            flush_q      <= 1'b0;
            excp_valid_q <= 1'b0;
            eret_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (take) begin
                        state_q <= S_FLUSH;
                        busy_q  <= 1'b1;
                        flush_q <= 1'b1;
                        if (excp_hit) begin
                            excp_valid_q <= 1'b1;
                            new_pc_q     <= EXC_VECTOR;
                            excp_code_q  <= excp_code_d;
                            excp_epc_q   <= excp_epc_d;
                            excp_bd_q    <= excp_bd_d;
                        end else begin
                            eret_q   <= 1'b1;
                            new_pc_q <= eff_epc;
                        end
                    end
                end
                S_FLUSH: begin
                    state_q <= S_BLANK;
                    cnt_q   <= 2'd0;
                end
                S_BLANK: begin
                    // Two refill bubbles, then accept events again.
                    if (cnt_q == 2'd1) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 2'd0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 2'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign flush_o      = flush_q;
    assign new_pc_o     = new_pc_q;
    assign excp_valid_o = excp_valid_q;
    assign excp_code_o  = excp_code_q;
    assign excp_epc_o   = excp_epc_q;
    assign excp_bd_o    = excp_bd_q;
    assign eret_o       = eret_q;
    assign busy_o       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_excp_ctrl.sv
// ============================================================================
// Module   : tb_excp_ctrl
// Purpose  : Directed self-checking bench for excp_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_excp_ctrl;

    logic        clk;
    logic        rst_n;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delay_slot_i;
    logic [4:0]  mem_excp_i;
    logic        cp0_we_i;
    logic [4:0]  cp0_waddr_i;
    logic [31:0] cp0_wdata_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        excp_valid_o;
    logic [4:0]  excp_code_o;
    logic [31:0] excp_epc_o;
    logic        excp_bd_o;
    logic        eret_o;
    logic        busy_o;

    int n_chk;
    int n_pass;

    excp_ctrl u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .mem_valid_i         (mem_valid_i),
        .mem_pc_i            (mem_pc_i),
        .mem_in_delay_slot_i (mem_in_delay_slot_i),
        .mem_excp_i          (mem_excp_i),
        .cp0_we_i            (cp0_we_i),
        .cp0_waddr_i         (cp0_waddr_i),
        .cp0_wdata_i         (cp0_wdata_i),
        .status_i            (status_i),
        .cause_i             (cause_i),
        .epc_i               (epc_i),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o),
        .excp_valid_o        (excp_valid_o),
        .excp_code_o         (excp_code_o),
        .excp_epc_o          (excp_epc_o),
        .excp_bd_o           (excp_bd_o),
        .eret_o              (eret_o),
        .busy_o              (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic ds, input logic [4:0] excp);
        mem_valid_i         = 1'b1;
        mem_pc_i            = pc;
        mem_in_delay_slot_i = ds;
        mem_excp_i          = excp;
    endtask

    task automatic quiet();
        mem_valid_i         = 1'b0;
        mem_pc_i            = 32'd0;
        mem_in_delay_slot_i = 1'b0;
        mem_excp_i          = 5'd0;
        cp0_we_i            = 1'b0;
        cp0_waddr_i         = 5'd0;
        cp0_wdata_i         = 32'd0;
    endtask

    // Let FLUSH + 2 BLANK cycles drain back to IDLE.
    task automatic drain();
        quiet();
        tick();
        tick();
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".flush"},  {31'd0, flush_o},      32'd0);
        chk({tag, ".busy"},   {31'd0, busy_o},       32'd0);
        chk({tag, ".valid"},  {31'd0, excp_valid_o}, 32'd0);
        chk({tag, ".eret"},   {31'd0, eret_o},       32'd0);
        chk({tag, ".newpc"},  new_pc_o,              32'd0);
        chk({tag, ".code"},   {27'd0, excp_code_o},  32'd0);
        chk({tag, ".epc"},    excp_epc_o,            32'd0);
        chk({tag, ".bd"},     {31'd0, excp_bd_o},    32'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        status_i = 32'd0;
        cause_i  = 32'd0;
        epc_i    = 32'd0;
        quiet();
        #22;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Syscall, busy window of three cycles.
        drive(32'h100, 1'b0, 5'b00001);
        tick();
        chk("sys.flush", {31'd0, flush_o}, 32'd1);
        chk("sys.valid", {31'd0, excp_valid_o}, 32'd1);
        chk("sys.eret",  {31'd0, eret_o}, 32'd0);
        chk("sys.newpc", new_pc_o, 32'h20);
        chk("sys.code",  {27'd0, excp_code_o}, 32'h08);
        chk("sys.epc",   excp_epc_o, 32'h100);
        chk("sys.bd",    {31'd0, excp_bd_o}, 32'd0);
        chk("sys.busy1", {31'd0, busy_o}, 32'd1);
        quiet();
        tick();
        chk("sys.flush2", {31'd0, flush_o}, 32'd0);
        chk("sys.valid2", {31'd0, excp_valid_o}, 32'd0);
        chk("sys.busy2",  {31'd0, busy_o}, 32'd1);
        tick();
        chk("sys.busy3",  {31'd0, busy_o}, 32'd1);
        tick();
        chk("sys.busy4",  {31'd0, busy_o}, 32'd0);
        chk("sys.hold",   new_pc_o, 32'h20);

        // Interrupt wins over reserved instruction.
        status_i = 32'h0000_0401;
        cause_i  = 32'h0000_0400;
        drive(32'h300, 1'b0, 5'b00100);
        tick();
        chk("int.flush", {31'd0, flush_o}, 32'd1);
        chk("int.code",  {27'd0, excp_code_o}, 32'h00);
        chk("int.valid", {31'd0, excp_valid_o}, 32'd1);
        drain();
        status_i = 32'd0;
        cause_i  = 32'd0;

        // Overflow in delay slot.
        drive(32'h204, 1'b1, 5'b01000);
        tick();
        chk("ov.epc",  excp_epc_o, 32'h200);
        chk("ov.bd",   {31'd0, excp_bd_o}, 32'd1);
        chk("ov.code", {27'd0, excp_code_o}, 32'h0C);
        drain();

        // Eret with EPC bypass.
        epc_i       = 32'h40;
        cp0_we_i    = 1'b1;
        cp0_waddr_i = 5'd14;
        cp0_wdata_i = 32'h80;
        drive(32'h500, 1'b0, 5'b10000);
        tick();
        chk("eret.newpc", new_pc_o, 32'h80);
        chk("eret.eret",  {31'd0, eret_o}, 32'd1);
        chk("eret.valid", {31'd0, excp_valid_o}, 32'd0);
        chk("eret.flush", {31'd0, flush_o}, 32'd1);
        drain();
        epc_i = 32'd0;

        // Syscall then break during refill: break dropped.
        drive(32'h600, 1'b0, 5'b00001);
        tick();
        chk("drop.flush1", {31'd0, flush_o}, 32'd1);
        drive(32'h604, 1'b0, 5'b00010);
        tick();
        chk("drop.flush2", {31'd0, flush_o}, 32'd0);
        tick();
        chk("drop.flush3", {31'd0, flush_o}, 32'd0);
        chk("drop.code",   {27'd0, excp_code_o}, 32'h08);
        chk("drop.valid",  {31'd0, excp_valid_o}, 32'd0);
        quiet();
        tick();
        chk("drop.busy",   {31'd0, busy_o}, 32'd0);
        tick();
        chk("drop.flush4", {31'd0, flush_o}, 32'd0);

        // Priority: reserved beats syscall/break/overflow.
        drive(32'h700, 1'b0, 5'b01111);
        tick();
        chk("pri.ri", {27'd0, excp_code_o}, 32'h0A);
        drain();
        // Break beats overflow and eret.
        drive(32'h704, 1'b0, 5'b11010);
        tick();
        chk("pri.bp",   {27'd0, excp_code_o}, 32'h09);
        chk("pri.eret", {31'd0, eret_o}, 32'd0);
        drain();

        // No event cases.
        drive(32'h800, 1'b0, 5'b00000);
        tick();
        chk("none.flush", {31'd0, flush_o}, 32'd0);
        chk("none.busy",  {31'd0, busy_o}, 32'd0);
        quiet();
        mem_excp_i = 5'b00001;
        tick();
        chk("novalid.flush", {31'd0, flush_o}, 32'd0);
        quiet();

        // Cause bypass only touches bits [9:8].
        status_i    = 32'h0000_0401;
        cp0_we_i    = 1'b1;
        cp0_waddr_i = 5'd13;
        cp0_wdata_i = 32'h0000_0400;
        mem_valid_i = 1'b1;
        tick();
        chk("cbyp.hi.flush", {31'd0, flush_o}, 32'd0);
        status_i    = 32'h0000_0201;
        cp0_wdata_i = 32'h0000_0200;
        tick();
        chk("cbyp.sw.flush", {31'd0, flush_o}, 32'd1);
        chk("cbyp.sw.code",  {27'd0, excp_code_o}, 32'h00);
        drain();

        // Status bypass enables interrupt; EXL masks it.
        status_i    = 32'd0;
        cause_i     = 32'h0000_0400;
        cp0_we_i    = 1'b1;
        cp0_waddr_i = 5'd12;
        cp0_wdata_i = 32'h0000_0401;
        drive(32'h900, 1'b0, 5'b00010);
        tick();
        chk("sbyp.code", {27'd0, excp_code_o}, 32'h00);
        drain();
        status_i = 32'h0000_0403;
        drive(32'h904, 1'b0, 5'b00001);
        tick();
        chk("exl.code", {27'd0, excp_code_o}, 32'h08);
        drain();
        status_i = 32'd0;
        cause_i  = 32'd0;

        // Reset during BLANK aborts sequence.
        drive(32'hA00, 1'b0, 5'b00001);
        tick();
        quiet();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rstblank");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post.flush1", {31'd0, flush_o}, 32'd0);
        chk("post.busy1",  {31'd0, busy_o}, 32'd0);
        tick();
        tick();
        chk("post.flush3", {31'd0, flush_o}, 32'd0);
        chk("post.valid3", {31'd0, excp_valid_o}, 32'd0);

        // Delay-slot EPC wraps modulo 2^32.
        drive(32'h0, 1'b1, 5'b01000);
        tick();
        chk("wrap.epc", excp_epc_o, 32'hFFFF_FFFC);
        chk("wrap.bd",  {31'd0, excp_bd_o}, 32'd1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
